vc_input_port: RTL and testbench

- Parametrised router input port, successor to the two-VC ring input stage.
- Accepts flits on one link with a valid/ready handshake and steers each flit into one of NUM_VC per-VC FIFOs of depth DEPTH, selected by the vc_sel input.
- Decodes each FIFO head's hop field into a request for the PE port (hop == 0) or the onward ring port (hop != 0).
- Pops the head on grant; optionally decrements the hop field on ring-bound flits. Sits between the link receiver and the output arbiters.

---
 rtl/vc_input_port.sv | 122 ++++++++++++
 tb/tb_vc_input_port.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_port.sv
// Router input port: steers link flits into NUM_VC independent FIFOs and
// requests the PE or ring output based on each head flit's hop field.
module vc_input_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2,
  parameter int VC_W       = 1,
  parameter int DEPTH      = 4,
  parameter int HOP_LSB    = 48,
  parameter int HOP_W      = 8,
  parameter int DEC_HOP    = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    si,
  output logic                                    ri,
  input  logic [DATA_WIDTH-1:0]                   di,
  input  logic [VC_W-1:0]                         vc_sel,
  output logic [NUM_VC-1:0]                       req_cw,
  output logic [NUM_VC-1:0]                       req_pe,
  input  logic [NUM_VC-1:0]                       gnt_cw,
  input  logic [NUM_VC-1:0]                       gnt_pe,
  output logic [NUM_VC*DATA_WIDTH-1:0]            data_out,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0]     occupancy,
  output logic                                    ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]      cnt_q    [NUM_VC];
  logic [CNT_W-1:0]      cnt_d    [NUM_VC];
  logic                  ovf_q;
  logic                  ovf_d;

  logic [NUM_VC-1:0]     full;
  logic [NUM_VC-1:0]     empty;
  logic [NUM_VC-1:0]     push_v;
  logic [NUM_VC-1:0]     pop_v;
  logic                  push;
  logic [DATA_WIDTH-1:0] head [NUM_VC];

  // Ring-bound view of a flit: hop field minus one, everything else intact.
  function automatic logic [DATA_WIDTH-1:0] dec_hop(input logic [DATA_WIDTH-1:0] flit);
    logic [DATA_WIDTH-1:0] r;
    r = flit;
    r[HOP_LSB +: HOP_W] = flit[HOP_LSB +: HOP_W] - HOP_W'(1);
    return r;
  endfunction

  always_comb begin
    full      = '0;
    empty     = '0;
    req_cw    = '0;
    req_pe    = '0;
    data_out  = '0;
    occupancy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      head[v]  = mem_q[v][rd_ptr_q[v]];
      full[v]  = (cnt_q[v] == CNT_W'(DEPTH));
      empty[v] = (cnt_q[v] == '0);
      req_pe[v] = !empty[v] && (head[v][HOP_LSB +: HOP_W] == '0);
      req_cw[v] = !empty[v] && (head[v][HOP_LSB +: HOP_W] != '0);
      if (empty[v]) begin
        data_out[v*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (req_cw[v] && (DEC_HOP != 0)) begin
        data_out[v*DATA_WIDTH +: DATA_WIDTH] = dec_hop(head[v]);
      end else begin
        data_out[v*DATA_WIDTH +: DATA_WIDTH] = head[v];
      end
      occupancy[v*CNT_W +: CNT_W] = cnt_q[v];
    end
  end

  // A full VC refuses input even if it pops in the same cycle.
  assign ri      = !full[vc_sel];
  assign push    = si && ri;
  assign ovf_err = ovf_q;

  always_comb begin
    ovf_d  = ovf_q || (si && !ri);
    push_v = '0;
    pop_v  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_v[v]   = push && (vc_sel == VC_W'(v));
      pop_v[v]    = (gnt_cw[v] && req_cw[v]) || (gnt_pe[v] && req_pe[v]);
      wr_ptr_d[v] = push_v[v] ? wr_ptr_q[v] + PTR_W'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = pop_v[v]  ? rd_ptr_q[v] + PTR_W'(1) : rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v] + CNT_W'(push_v[v]) - CNT_W'(pop_v[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
    end
  end

  // Storage needs no reset: counts gate every read of it.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_v[v]) mem_q[v][wr_ptr_q[v]] <= di;
    end
  end

endmodule

// File: tb/tb_vc_input_port.sv
// Bench for vc_input_port: directed vector table plus per-VC scoreboard queues.
module tb_vc_input_port;

  localparam int DW    = 64;
  localparam int NV    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              si;
  logic              ri;
  logic [DW-1:0]     di;
  logic              vc_sel;
  logic [NV-1:0]     req_cw, req_pe, gnt_cw, gnt_pe;
  logic [NV*DW-1:0]  data_out;
  logic [NV*CW-1:0]  occupancy;
  logic              ovf_err;

  vc_input_port dut (
    .clk(clk), .rst(rst), .si(si), .ri(ri), .di(di), .vc_sel(vc_sel),
    .req_cw(req_cw), .req_pe(req_pe), .gnt_cw(gnt_cw), .gnt_pe(gnt_pe),
    .data_out(data_out), .occupancy(occupancy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];
  bit m_ovf;

  typedef struct {
    bit            si;
    bit            vc;
    logic [DW-1:0] di;
    logic [1:0]    gcw;
    logic [1:0]    gpe;
    int            occ0;
    int            occ1;
    bit            ovf;
  } vec_t;

  vec_t tbl[17];

  localparam logic [DW-1:0] FA = 64'h0003_0000_0000_00AA;
  localparam logic [DW-1:0] FP = 64'h0000_0000_0000_00BB;
  localparam logic [DW-1:0] A  = 64'h0001_0000_0000_00A1;
  localparam logic [DW-1:0] B  = 64'h0000_0000_0000_00B2;
  localparam logic [DW-1:0] C  = 64'h0002_0000_0000_00C3;
  localparam logic [DW-1:0] D  = 64'h0000_0000_0000_00D4;
  localparam logic [DW-1:0] E  = 64'h0007_0000_0000_00E5;
  localparam logic [DW-1:0] F  = 64'h0005_0000_0000_00F6;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] f);
    logic [DW-1:0] r;
    r = f;
    if (f[55:48] != 8'd0) r[55:48] = f[55:48] - 8'd1;
    return r;
  endfunction

  function automatic int msize(input int v);
    return (v == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [DW-1:0] mfront(input int v);
    return (v == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    m_ovf = 1'b0;
  endtask

  // Drive one cycle, check pre-edge outputs against the model, then advance.
  task automatic step(input bit s, input bit v, input logic [DW-1:0] d,
                      input logic [1:0] gcw, input logic [1:0] gpe);
    logic [1:0]    ecw, epe;
    logic [DW-1:0] exp;
    bit            efull;
    si = s; vc_sel = v; di = d; gnt_cw = gcw; gnt_pe = gpe;
    #1;
    ecw = '0; epe = '0;
    for (int k = 0; k < NV; k++) begin
      if (msize(k) > 0) begin
        ecw[k] = (mfront(k)[55:48] != 8'd0);
        epe[k] = (mfront(k)[55:48] == 8'd0);
      end
    end
    efull = (msize(v) == DEPTH);
    chk("ri", 64'(ri), 64'(!efull));
    chk("req_cw", 64'(req_cw), 64'(ecw));
    chk("req_pe", 64'(req_pe), 64'(epe));
    chk("occupancy", 64'(occupancy), 64'({3'(msize(1)), 3'(msize(0))}));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    for (int k = 0; k < NV; k++) begin
      if ((gcw[k] && ecw[k]) || (gpe[k] && epe[k])) begin
        if (k == 0) exp = sb0.pop_front(); else exp = sb1.pop_front();
        chk("head_pop", data_out[k*DW +: DW], exp_out(exp));
      end
    end
    if (s && !efull) begin
      if (v == 0) sb0.push_back(d); else sb1.push_back(d);
    end else if (s) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] f;
    int            guard;

    tbl[0]  = '{1'b1, 1'b0, FA, 2'b00, 2'b00, 1, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, '0, 2'b01, 2'b00, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, FP, 2'b00, 2'b00, 0, 1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, '0, 2'b10, 2'b00, 0, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, '0, 2'b00, 2'b10, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, A,  2'b00, 2'b00, 1, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, B,  2'b00, 2'b00, 2, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, C,  2'b00, 2'b00, 3, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, D,  2'b00, 2'b00, 4, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, E,  2'b00, 2'b00, 4, 0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, '0, 2'b00, 2'b00, 4, 0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, F,  2'b01, 2'b00, 3, 0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, F,  2'b00, 2'b01, 3, 0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, '0, 2'b01, 2'b00, 2, 0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, '0, 2'b00, 2'b01, 1, 0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, '0, 2'b01, 2'b00, 0, 0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, '0, 2'b11, 2'b11, 0, 0, 1'b1};

    rst = 1'b0; si = 1'b0; vc_sel = 1'b0; di = '0; gnt_cw = '0; gnt_pe = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_ri", 64'(ri), 64'd1);
    chk("rst_req_cw", 64'(req_cw), 64'd0);
    chk("rst_req_pe", 64'(req_pe), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].si, tbl[i].vc, tbl[i].di, tbl[i].gcw, tbl[i].gpe);
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy),
          64'({3'(tbl[i].occ1), 3'(tbl[i].occ0)}));
      chk($sformatf("tbl%0d_ovf", i), 64'(ovf_err), 64'(tbl[i].ovf));
      if (i == 0) chk("dec_hop_vc0", data_out[63:0], 64'h0002_0000_0000_00AA);
      if (i == 2) chk("pe_vc1_raw", data_out[127:64], FP);
    end

    // Mid-stream reset drops buffered flits, requests and the sticky error.
    step(1'b1, 1'b0, A, 2'b00, 2'b00);
    step(1'b1, 1'b1, B, 2'b00, 2'b00);
    step(1'b1, 1'b0, C, 2'b00, 2'b00);
    si = 1'b0; gnt_cw = '0; gnt_pe = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("mid_rst_req_cw", 64'(req_cw), 64'd0);
    chk("mid_rst_req_pe", 64'(req_pe), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_err), 64'd0);
    chk("mid_rst_ri", 64'(ri), 64'd1);
    step(1'b0, 1'b0, '0, 2'b11, 2'b11);

    for (int i = 0; i < 20; i++) begin
      f = {$urandom, $urandom};
      f[55:48] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      step(1'b1, 1'(i % 2), f, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1)
        step(1'b0, 1'($urandom_range(0, 1)), '0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    guard = 0;
    while ((sb0.size() + sb1.size()) > 0 && guard < 50) begin
      step(1'b0, 1'b0, '0, 2'b11, 2'b11);
      guard++;
    end
    chk("drain_timeout", 64'(sb0.size() + sb1.size()), 64'd0);
    step(1'b0, 1'b0, '0, 2'b11, 2'b11);
    chk("final_occ", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
